// File: rtl/number_display_ctrl_pkg.sv
// Shared segment constants, FSM state type and the double-dabble helper for number_display_ctrl.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package number_display_ctrl_pkg;

    localparam logic [6:0] ZERO  = 7'h40;
    localparam logic [6:0] ONE   = 7'h79;
    localparam logic [6:0] TWO   = 7'h24;
    localparam logic [6:0] THREE = 7'h30;
    localparam logic [6:0] FOUR  = 7'h19;
    localparam logic [6:0] FIVE  = 7'h12;
    localparam logic [6:0] SIX   = 7'h02;
    localparam logic [6:0] SEVEN = 7'h78;
    localparam logic [6:0] EIGHT = 7'h00;
    localparam logic [6:0] NINE  = 7'h10;
    localparam logic [6:0] NONE  = 7'h7F;
    localparam logic [6:0] NEGA  = 7'h3F;

    localparam logic [2:0] LAST_SHIFT = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        SHIFT,
        ENC
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/number_display_ctrl_if.sv
// Value/load/ready handshake plus the four registered segment buses of number_display_ctrl.
interface number_display_ctrl_if;
    logic [7:0] value;
    logic       load;
    logic       ready;
    logic [6:0] digits;
    logic [6:0] ten_digits;
    logic [6:0] hun_digits;
    logic [6:0] sign;

    modport master (
        output value, load,
        input  ready, digits, ten_digits, hun_digits, sign
    );

    modport slave (
        input  value, load,
        output ready, digits, ten_digits, hun_digits, sign
    );
endinterface

// File: rtl/number_display_ctrl_seg7_encode.sv
// Combinational BCD digit to active-low seven-segment pattern; anything above 9 shows blank.
module seg7_encode
    import number_display_ctrl_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = NONE;
        case (bcd_i)
            4'd0:    seg_o = ZERO;
            4'd1:    seg_o = ONE;
            4'd2:    seg_o = TWO;
            4'd3:    seg_o = THREE;
            4'd4:    seg_o = FOUR;
            4'd5:    seg_o = FIVE;
            4'd6:    seg_o = SIX;
            4'd7:    seg_o = SEVEN;
            4'd8:    seg_o = EIGHT;
            4'd9:    seg_o = NINE;
            default: seg_o = NONE;
        endcase
    end

endmodule

// File: rtl/number_display_ctrl.sv
// Handshaked 8-bit value -> sign + 3 BCD digits via a 10-cycle double-dabble FSM, registered segments.
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module number_display_ctrl
    import number_display_ctrl_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    number_display_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic [7:0]  value_q, value_d;
    logic        neg_q, neg_d;
    logic [7:0]  mag_q, mag_d;
    logic [11:0] bcd_q, bcd_d;
    logic [2:0]  count_q, count_d;
    logic [6:0]  digits_q, digits_d;
    logic [6:0]  ten_q, ten_d;
    logic [6:0]  hun_q, hun_d;
    logic [6:0]  sign_q, sign_d;

    logic [11:0] bcd_adj;
    logic [6:0]  seg_w [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_enc
            seg7_encode u_enc (
                .bcd_i (bcd_q[gi*4 +: 4]),
                .seg_o (seg_w[gi])
            );
            assign bcd_adj[gi*4 +: 4] = bcd_add3(bcd_q[gi*4 +: 4]);
        end
    endgenerate

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            value_q  <= '0;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            bcd_q    <= '0;
            count_q  <= '0;
            digits_q <= ZERO;
            ten_q    <= ZERO;
            hun_q    <= ZERO;
            sign_q   <= NONE;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            neg_q    <= neg_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
            count_q  <= count_d;
            digits_q <= digits_d;
            ten_q    <= ten_d;
            hun_q    <= hun_d;
            sign_q   <= sign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        neg_d    = neg_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        count_d  = count_q;
        digits_d = digits_q;
        ten_d    = ten_q;
        hun_d    = hun_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    value_d = bus.value;
                    state_d = ABS;
                end
            end
            ABS: begin
                // -128 negates to 8'h80, which reads correctly as unsigned 128.
                if (SIGNED_MODE && value_q[7]) begin
                    neg_d = 1'b1;
                    mag_d = ~value_q + 8'd1;
                end else begin
                    neg_d = 1'b0;
                    mag_d = value_q;
                end
                bcd_d   = '0;
                count_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj[10:0], mag_q, 1'b0};
                count_d = count_q + 3'd1;
                if (count_q == LAST_SHIFT) begin
                    state_d = ENC;
                end
            end
            ENC: begin
                digits_d = seg_w[0];
                ten_d    = seg_w[1];
                hun_d    = seg_w[2];
`ifdef LEADING_ZERO_BLANK_EN
                if (bcd_q[11:8] == 4'd0) begin
                    hun_d = NONE;
                    if (bcd_q[7:4] == 4'd0) begin
                        ten_d = NONE;
                    end
                end
`endif
                sign_d  = neg_q ? NEGA : NONE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready      = (state_q == IDLE);
    assign bus.digits     = digits_q;
    assign bus.ten_digits = ten_q;
    assign bus.hun_digits = hun_q;
    assign bus.sign       = sign_q;

endmodule
